// File: rtl/pencoder_rr.sv
// pencoder_rr: registered N-line priority encoder with fixed (MSB-first) and
// round-robin modes. A rotating pointer ptr names the highest-priority line in
// round-robin mode; after a grant at index k it moves to k-1 (mod N) so line k
// drops to lowest priority. All outputs are registered, one cycle of latency.
// Optional feature: define PENC_LOCK_EN to add a 'lock' input that holds the
// current grant while its request line stays asserted.
module pencoder_rr #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
`ifdef PENC_LOCK_EN
  input  logic         lock,
`endif
  input  logic [N-1:0] D_in,
  output logic [W-1:0] Q_out,
  output logic [N-1:0] grant,
  output logic         v
);

  logic [W-1:0] q_out_q, q_out_d;
  logic [N-1:0] grant_q, grant_d;
  logic         v_q, v_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         hit;
  logic [W-1:0] hit_idx;
  logic [W-1:0] idx_w;
  logic         hold;
  int           start_idx;
  int           idx;

  // Lock keeps the current grant while its line is still requesting.
`ifdef PENC_LOCK_EN
  assign hold = lock & v_q & D_in[q_out_q];
`else
  assign hold = 1'b0;
`endif

  // Descending search from the start index with modulo-N wrap; the first
  // set request wins. Fixed mode simply starts the search at N-1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hit       = 1'b0;
    hit_idx   = '0;
    idx_w     = '0;
    idx       = 0;
    start_idx = mode ? int'(ptr_q) : N - 1;
    for (int j = 0; j < N; j++) begin
      idx = start_idx - j;
      if (idx < 0) idx = idx + N;
      idx_w = W'(idx);
      if (!hit && D_in[idx_w]) begin
        hit     = 1'b1;
        hit_idx = idx_w;
      end
    end
  end

  // Next-state: new grant unless locked; pointer only advances on a
  // round-robin grant and wraps modulo N so it never reaches N.
  always_comb begin
    q_out_d = q_out_q;
    grant_d = grant_q;
    v_d     = v_q;
    ptr_d   = ptr_q;
    if (!hold) begin
      v_d     = hit;
      q_out_d = hit_idx;
      grant_d = hit ? (N'(1) << hit_idx) : '0;
      if (mode && hit) begin
        ptr_d = (hit_idx == '0) ? W'(N - 1) : hit_idx - W'(1);
      end
    end
  end

  // State registers: async clear, update only on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
      q_out_q <= '0;
      grant_q <= '0;
      v_q     <= 1'b0;
      ptr_q   <= W'(N - 1);
    end else if (en) begin
      q_out_q <= q_out_d;
      grant_q <= grant_d;
      v_q     <= v_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Q_out = q_out_q;
  assign grant = grant_q;
  assign v     = v_q;

endmodule

// File: tb/tb_pencoder_rr.sv
// Bench for pencoder_rr: two instances (N=8 and N=5) share the stimulus.
// A priority-key reference model predicts each response; expectations are
// queued with a due half-cycle tick and a separate monitor compares them.
module tb_pencoder_rr;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       mode  = 1'b0;
  logic       lock  = 1'b0;
  logic [7:0] d8    = '0;
  logic [4:0] d5    = '0;
  logic [2:0] q8, q5;
  logic [7:0] g8;
  logic [4:0] g5;
  logic       v8, v5;

  always #5 clk = ~clk;

  pencoder_rr #(.N(8), .W(3)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
`ifdef PENC_LOCK_EN
    .lock  (lock),
`endif
    .D_in  (d8),
    .Q_out (q8),
    .grant (g8),
    .v     (v8)
  );

  pencoder_rr #(.N(5), .W(3)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
`ifdef PENC_LOCK_EN
    .lock  (lock),
`endif
    .D_in  (d5),
    .Q_out (q5),
    .grant (g5),
    .v     (v5)
  );

  typedef struct {
    int   ptr;
    int   q;
    logic v;
  } mstate_t;

  typedef struct {
    int         due;
    int         id;
    int         q;
    logic [7:0] g;
    logic       v;
  } exp_t;

  exp_t    sbq[$];
  mstate_t m8, m5;
  int      t           = 0;
  int      vectors     = 0;
  int      miscompares = 0;

  // Reference: line i's priority is (i - start - 1) mod n, highest wins.
  function automatic mstate_t model_next(mstate_t s, int n, logic e, logic m, logic [7:0] d);
    mstate_t r;
    int best, best_key, start, key;
    r        = s;
    best     = -1;
    best_key = -1;
    if (!e) return s;
`ifdef PENC_LOCK_EN
    if (lock && s.v && (((d >> s.q) & 8'd1) != 8'd0)) return s;
`endif
    start = m ? s.ptr : n - 1;
    for (int i = 0; i < n; i++) begin
      if (((d >> i) & 8'd1) != 8'd0) begin
        key = (i - start - 1 + 2 * n) % n;
        if (key > best_key) begin
          best_key = key;
          best     = i;
        end
      end
    end
    if (best < 0) begin
      r.v = 1'b0;
      r.q = 0;
    end else begin
      r.v = 1'b1;
      r.q = best;
      if (m) r.ptr = (best + n - 1) % n;
    end
    return r;
  endfunction

  task automatic push(input int due, input int id, input mstate_t s);
    exp_t e;
    e.due = due;
    e.id  = id;
    e.q   = s.q;
    e.v   = s.v;
    e.g   = s.v ? (8'd1 << s.q) : 8'd0;
    sbq.push_back(e);
  endtask

  task automatic check(input string name, input logic ok, input exp_t e,
                       input logic [2:0] aq, input logic [7:0] ag, input logic av);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s tick=%0d: got q=%0d grant=%b v=%b, want q=%0d grant=%b v=%b",
               name, t, aq, ag, av, e.q, e.g, e.v);
    end
  endtask

  // Called at posedge+2: drive inputs, predict the state after the next edge.
  task automatic apply(input logic e_, input logic m_, input logic [7:0] d8_,
                       input logic [4:0] d5_, input logic lk_);
    en   = e_;
    mode = m_;
    d8   = d8_;
    d5   = d5_;
    lock = lk_;
    m8 = model_next(m8, 8, e_, m_, d8_);
    m5 = model_next(m5, 5, e_, m_, {3'b000, d5_});
    push(t + 2, 0, m8);
    push(t + 2, 1, m5);
    @(posedge clk);
    #2;
  endtask

  // Reset asserted between edges; outputs must be clear by the next negedge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    m8 = '{ptr: 7, q: 0, v: 1'b0};
    m5 = '{ptr: 4, q: 0, v: 1'b0};
    push(t + 1, 0, m8);
    push(t + 1, 1, m5);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push(t + 1, 0, m8);
    push(t + 1, 1, m5);
  endtask

  // Monitor: sample 1 time unit after each clock edge, compare due entries.
  initial begin
    exp_t       e;
    logic [2:0] aq;
    logic [7:0] ag;
    logic       av;
    forever begin
      @(clk);
      #1;
      t++;
      while (sbq.size() > 0 && sbq[0].due <= t) begin
        e = sbq.pop_front();
        if (e.id == 0) begin
          aq = q8; ag = g8; av = v8;
        end else begin
          aq = q5; ag = {3'b000, g5}; av = v5;
        end
        check(e.id == 0 ? "n8_out" : "n5_out",
              (e.due == t) && (aq === 3'(e.q)) && (ag === e.g) && (av === e.v),
              e, aq, ag, av);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #2;
    reset_pulse();

    // Fixed priority, then enable hold, then release.
    apply(1'b1, 1'b0, 8'b0010_0110, 5'b00110, 1'b0);
    repeat (3) apply(1'b0, 1'b0, 8'b0000_0001, 5'b00001, 1'b0);
    apply(1'b1, 1'b0, 8'b0000_0001, 5'b00001, 1'b0);

    // Round-robin fairness and wrap (N=5 alternates 4,0).
    reset_pulse();
    repeat (4) apply(1'b1, 1'b1, 8'b1000_0001, 5'b10001, 1'b0);
    repeat (8) apply(1'b1, 1'b1, 8'hFF, 5'b11111, 1'b0);

    // Empty requests in both modes, then a single request in round-robin.
    apply(1'b1, 1'b0, 8'h00, 5'b00000, 1'b0);
    apply(1'b1, 1'b1, 8'h00, 5'b00000, 1'b0);
    apply(1'b1, 1'b1, 8'b0000_1000, 5'b01000, 1'b0);

    // Async reset mid-rotation after grants 7, 6.
    reset_pulse();
    repeat (2) apply(1'b1, 1'b1, 8'hFF, 5'b11111, 1'b0);
    reset_pulse();
    apply(1'b1, 1'b1, 8'hFF, 5'b11111, 1'b0);

    // Lock on the first grant while its line stays high, then drop it.
    reset_pulse();
    apply(1'b1, 1'b1, 8'b1000_0001, 5'b10001, 1'b0);
    repeat (3) apply(1'b1, 1'b1, 8'b1000_0001, 5'b10001, 1'b1);
    apply(1'b1, 1'b1, 8'b0000_0001, 5'b00001, 1'b1);

    // Randomised traffic with occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) reset_pulse();
      apply(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            8'($urandom & $urandom), 5'($urandom & $urandom),
            1'($urandom_range(0, 1)));
    end

    en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
